icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache directly upstream of the fetch stage.
- Serves fetch's single-outstanding request/ack interface: `addr_ready`/`addr` in, `cache_ack`/`inst` out.
- On a miss, refills a full line from the instruction memory port using a request/grant handshake followed by per-word beats.
- Supports a whole-cache invalidate (`flush`) for `fence.i`.

Parameters:
- LINES, 16, number of cache lines (power of 2, ≥2).
- WORDS, 4, 32-bit words per line (power of 2, ≥2).
- Derived, not overridable:
  - OFF_W = log2(WORDS)+2
  - IDX_W = log2(LINES)
  - TAG_W = 32-OFF_W-IDX_W

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- addr_ready  in  1  fetch request strobe, one cycle per request.
- addr  in  32  byte address of the requested instruction.
- cache_ack  out  1  one-cycle pulse; `inst` is valid this cycle.
- inst  out  32  instruction word; 32'h00000013 whenever `cache_ack`=0.
- flush  in  1  invalidate all lines.
- mem_req  out  1  line refill request, held until granted.
- mem_addr  out  32  line-aligned refill address (low OFF_W bits 0).
- mem_gnt  in  1  memory accepts `mem_req` this cycle.
- mem_rvalid  in  1  one refill data beat this cycle.
- mem_rdata  in  32  beat data; beats return in ascending word order.

Behaviour:
- Address split:
  - `addr[1:0]` ignored.
  - word offset = `addr[OFF_W-1:2]`.
  - index = `addr[OFF_W+IDX_W-1:OFF_W]`.
  - tag = `addr[31:OFF_W+IDX_W]`.
- Storage: data array LINES×WORDS×32; tag array; valid bit per line.
- Reset (`rst`=0 at a clock edge):
  - state=IDLE; all valid bits cleared.
  - `cache_ack`=0, `inst`=NOP, `mem_req`=0, `mem_addr`=0.
  - beat counter=0; pending flush cleared.
  - Reset mid-refill abandons the fill. Beats arriving after reset are ignored. The partially written line stays invalid.
- State machine:
  - IDLE: if `addr_ready`, latch `addr` into req_addr → TAG. Otherwise stay.
  - TAG: compare the stored tag and valid bit at the index of req_addr.
    - Hit: `cache_ack`=1 and `inst`=word[offset] this cycle → IDLE. Hit latency is exactly 1 cycle (request in N, ack in N+1).
    - Miss: → REQ.
  - REQ: `mem_req`=1, `mem_addr`={req_addr[31:OFF_W], OFF_W'b0}. Both held stable until `mem_gnt`=1, then beat counter=0 → FILL.
  - FILL: each `mem_rvalid` writes `mem_rdata` to data[index][counter], then counter++. The beat with counter=WORDS-1 writes the tag, sets the valid bit, → RESP. `mem_rvalid` in any other state is ignored.
  - RESP: `cache_ack`=1, `inst`=data[index][offset] (the newly filled line) → IDLE.
- Miss latency: 1 (TAG) + grant wait + WORDS beat cycles + 1 (RESP).
- Exactly one `cache_ack` per accepted request.
- `addr_ready` in any state other than IDLE is ignored; fetch never issues while a request is outstanding.
- `addr_ready` in the same cycle as `cache_ack` is ignored, because the block is not yet in IDLE.
- Flush:
  - `flush` in IDLE or TAG: clears all valid bits at that edge.
  - If `flush` and a hit occur together in TAG, the hit still acks with the old data.
  - `flush` in REQ/FILL/RESP: sets a pending flag. The flag is applied on the cycle the block enters IDLE, after that fill's RESP ack. The filled line is therefore invalidated.
  - Simultaneous `flush` and `addr_ready` in IDLE: the request is accepted, invalidation is applied first, and the request misses.
- Conflict: a refill overwrites the existing line at that index unconditionally; there is no write-back (read-only cache).
- `mem_addr` is 0 whenever `mem_req`=0.

Test Plan:
- Cold miss:
  - Stimulus: after reset, `addr_ready` with `addr`=0x0000_0008; `mem_gnt` 2 cycles later; beats 0x11,0x22,0x33,0x44 back-to-back.
  - Response: `mem_req`=1 with `mem_addr`=0x0 until grant; `cache_ack` one cycle after the last beat with `inst`=0x33.
- Hit after fill:
  - Stimulus: request 0x0000_000C.
  - Response: `cache_ack` the next cycle with `inst`=0x44; `mem_req` stays 0.
- Conflict miss (LINES=16, WORDS=4):
  - Stimulus: request 0x0000_0100 (same index 0, different tag).
  - Response: refill issued with `mem_addr`=0x100. A later request to 0x0 misses again.
- Flush:
  - Stimulus: `flush` in IDLE, then request 0x8.
  - Response: miss and refill. Separately, `flush` during FILL → that request still acks with the fill data, then the same address misses next time.
- Reset mid-fill:
  - Stimulus: `rst`=0 after 2 of 4 beats; then `rst`=1, 2 stray `mem_rvalid` beats, then request 0x0.
  - Response: outputs at reset values; stray beats ignored; request misses; no `cache_ack` without a request.
- Ignored request:
  - Stimulus: `addr_ready` pulsed during REQ with `addr`=0x40.
  - Response: no second ack; only the original request is acked.

Source files
------------

// File: rtl/icache_dm_if.sv
// Fetch-side request/ack and instruction-memory refill signals of icache_dm.
// The slave modport is the cache side; master is the fetch stage/memory side.
interface icache_dm_if;
  logic        addr_ready;
  logic [31:0] addr;
  logic        cache_ack;
  logic [31:0] inst;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  addr_ready, addr, flush, mem_gnt, mem_rvalid, mem_rdata,
    output cache_ack, inst, mem_req, mem_addr
  );

  modport master (
    output addr_ready, addr, flush, mem_gnt, mem_rvalid, mem_rdata,
    input  cache_ack, inst, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, full-line refill on
// miss via request/grant plus ascending word beats, whole-cache flush for fence.i.
module icache_dm #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic       clk,
  input  logic       rst,
  icache_dm_if.slave bus
);
  localparam int          WSEL_W = $clog2(WORDS);
  localparam int          OFF_W  = WSEL_W + 2;
  localparam int          IDX_W  = $clog2(LINES);
  localparam int          TAG_W  = 32 - OFF_W - IDX_W;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef enum logic [2:0] {IDLE, TAG, REQ, FILL, RESP} state_t;

  state_t            state, state_nxt;
  logic [31:2]       req_addr;
  logic [WSEL_W-1:0] beat_cnt;
  logic              flush_pend;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES][WORDS];

  logic [IDX_W-1:0]  idx;
  logic [WSEL_W-1:0] off;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic              last_beat;
  logic              inv_all;
  logic              unused_addr_lsb;

  assign idx             = req_addr[OFF_W+IDX_W-1:OFF_W];
  assign off             = req_addr[OFF_W-1:2];
  assign tag             = req_addr[31:OFF_W+IDX_W];
  assign hit             = valid[idx] && (tag_mem[idx] == tag);
  assign last_beat       = bus.mem_rvalid && (beat_cnt == WSEL_W'(WORDS - 1));
  assign unused_addr_lsb = ^bus.addr[1:0];

  // A flush seen during a refill is deferred and lands on the first IDLE cycle,
  // so the line just filled is dropped right after its ack.
  assign inv_all = ((state == IDLE) || (state == TAG)) && (bus.flush || flush_pend);

  always_comb begin
    state_nxt     = state;
    bus.cache_ack = 1'b0;
    bus.inst      = NOP;
    bus.mem_req   = 1'b0;
    bus.mem_addr  = '0;
    case (state)
      IDLE: if (bus.addr_ready) state_nxt = TAG;
      TAG: begin
        if (hit) begin
          bus.cache_ack = 1'b1;
          bus.inst      = data_mem[idx][off];
          state_nxt     = IDLE;
        end else begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {req_addr[31:OFF_W], {OFF_W{1'b0}}};
        if (bus.mem_gnt) state_nxt = FILL;
      end
      FILL: if (last_beat) state_nxt = RESP;
      RESP: begin
        bus.cache_ack = 1'b1;
        bus.inst      = data_mem[idx][off];
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      req_addr   <= '0;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
      valid      <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && bus.addr_ready) req_addr <= bus.addr[31:2];
      if ((state == REQ) && bus.mem_gnt) beat_cnt <= '0;
      else if ((state == FILL) && bus.mem_rvalid) beat_cnt <= beat_cnt + 1'b1;
      if (inv_all) begin
        valid      <= '0;
        flush_pend <= 1'b0;
      end else begin
        if ((state == FILL) && last_beat) valid[idx] <= 1'b1;
        if (bus.flush && (state inside {REQ, FILL, RESP})) flush_pend <= 1'b1;
      end
    end
  end

  // Arrays carry no reset so they can map onto RAM; valid bits guard them.
  always_ff @(posedge clk) begin
    if (rst && (state == FILL) && bus.mem_rvalid) begin
      data_mem[idx][beat_cnt] <= bus.mem_rdata;
      if (last_beat) tag_mem[idx] <= tag;
    end
  end
endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed scenarios plus randomized traffic checked
// against a line-level cache model and a sparse instruction-memory image.
module tb_icache_dm;
  localparam int          LINES = 16;
  localparam int          WORDS = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  icache_dm_if bus();
  icache_dm #(.LINES(LINES), .WORDS(WORDS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int passed = 0;
  int total  = 0;

  // observations of the last transaction
  int          obs_acks, obs_lat, obs_gaps;
  logic [31:0] obs_inst, obs_mem_addr;
  bit          obs_miss, obs_addr_bad, obs_nop_bad, obs_flush_driven;

  // reference model
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  logic [31:0] m_data  [LINES][WORDS];
  logic [31:0] memimg  [int unsigned];

  function automatic int unsigned idx_of(input int unsigned a);
    return (a / (WORDS * 4)) % LINES;
  endfunction
  function automatic int unsigned off_of(input int unsigned a);
    return (a / 4) % WORDS;
  endfunction
  function automatic int unsigned tag_of(input int unsigned a);
    return a / (WORDS * 4 * LINES);
  endfunction
  function automatic int unsigned line_base(input int unsigned a);
    return a - (a % (WORDS * 4));
  endfunction
  function automatic logic [31:0] mem_word(input int unsigned a);
    int unsigned wa = a / 4;
    if (memimg.exists(wa)) return memimg[wa];
    return wa * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  task automatic model_invalidate();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_lookup(input int unsigned a, output bit hit, output logic [31:0] inst);
    int unsigned i = idx_of(a);
    hit  = m_valid[i] && (m_tag[i] == tag_of(a));
    inst = hit ? m_data[i][off_of(a)] : mem_word(a);
  endtask

  task automatic model_commit(input int unsigned a, input bit hit, input int flush_at);
    int unsigned i = idx_of(a);
    if (!hit) begin
      if (flush_at == 1) model_invalidate();
      m_valid[i] = 1'b1;
      m_tag[i]   = tag_of(a);
      for (int w = 0; w < WORDS; w++) m_data[i][w] = mem_word(line_base(a) + 4 * w);
    end
    if (flush_at >= 1 && obs_flush_driven && !(flush_at == 1 && !hit)) model_invalidate();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.addr_ready = 1'b0;
    bus.addr       = '0;
    bus.flush      = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  // Issues one request and plays the memory side; records what the cache did.
  task automatic run_req(input logic [31:0] a, input int g, input int gap_max,
                         input int flush_at, input int stray_at, input int abort_after);
    int  req_cycles = 0;
    int  beats      = 0;
    bit  granted    = 1'b0;
    obs_acks = 0; obs_lat = -1; obs_gaps = 0; obs_inst = NOP; obs_mem_addr = '0;
    obs_miss = 1'b0; obs_addr_bad = 1'b0; obs_nop_bad = 1'b0; obs_flush_driven = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (bus.cache_ack === 1'b1) begin
        obs_acks++;
        if (obs_lat < 0) begin obs_lat = cyc; obs_inst = bus.inst; end
      end else if (bus.inst !== NOP) obs_nop_bad = 1'b1;
      if (bus.mem_req === 1'b1) begin
        if (!obs_miss) obs_mem_addr = bus.mem_addr;
        else if (bus.mem_addr !== obs_mem_addr) obs_addr_bad = 1'b1;
        obs_miss = 1'b1;
      end else if (bus.mem_addr !== 32'h0) obs_addr_bad = 1'b1;
      if (obs_lat >= 0 && cyc >= obs_lat + 3) break;

      bus.addr_ready = (cyc == 0) || (cyc == stray_at);
      bus.addr       = (cyc == 0) ? a : 32'h0000_0040;
      bus.flush      = (cyc == flush_at);
      if (cyc == flush_at) obs_flush_driven = 1'b1;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      if (bus.mem_req === 1'b1 && !granted) begin
        if (req_cycles == g) begin bus.mem_gnt = 1'b1; granted = 1'b1; end
        else req_cycles++;
      end else if (granted && beats < WORDS) begin
        if (gap_max == 0 || $urandom_range(0, gap_max) != 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = mem_word(obs_mem_addr + 4 * beats);
          beats++;
        end else obs_gaps++;
      end
      step();
      if (abort_after >= 0 && granted && beats == abort_after) begin
        idle_inputs();
        return;
      end
    end
    idle_inputs();
  endtask

  task automatic transact(input logic [31:0] a, input int g, input int gap_max,
                          input int flush_at, input int stray_at,
                          output bit hit, output logic [31:0] exp_inst);
    if (flush_at == 0) model_invalidate();
    model_lookup(a, hit, exp_inst);
    run_req(a, g, gap_max, flush_at, stray_at, -1);
    model_commit(a, hit, flush_at);
  endtask

  task automatic flush_pulse();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    model_invalidate();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    step(); step(); step();
    total++; if (bus.cache_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", bus.cache_ack); else passed++;
    total++; if (bus.inst !== NOP) $display("FAIL reset_inst: got %h want %h", bus.inst, NOP); else passed++;
    total++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); else passed++;
    total++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); else passed++;
    rst = 1'b1;
    model_invalidate();
    step();
  endtask

  task automatic test_cold_miss();
    bit h; logic [31:0] e;
    memimg[0] = 32'h11; memimg[1] = 32'h22; memimg[2] = 32'h33; memimg[3] = 32'h44;
    transact(32'h0000_0008, 2, 0, -1, -1, h, e);
    total++; if (obs_miss !== 1'b1) $display("FAIL cold_miss_req: got %b want 1", obs_miss); else passed++;
    total++; if (obs_mem_addr !== 32'h0) $display("FAIL cold_mem_addr: got %h want 0", obs_mem_addr); else passed++;
    total++; if (obs_addr_bad !== 1'b0) $display("FAIL cold_mem_addr_stable: got %b want 0", obs_addr_bad); else passed++;
    total++; if (obs_inst !== 32'h33) $display("FAIL cold_inst: got %h want 33", obs_inst); else passed++;
    total++; if (obs_lat !== 9) $display("FAIL cold_latency: got %0d want 9", obs_lat); else passed++;
    total++; if (obs_acks !== 1) $display("FAIL cold_ack_count: got %0d want 1", obs_acks); else passed++;
  endtask

  task automatic test_hit();
    bit h; logic [31:0] e;
    memimg[3] = 32'hDEAD_BEEF;
    transact(32'h0000_000C, 0, 0, -1, -1, h, e);
    total++; if (obs_miss !== 1'b0) $display("FAIL hit_no_req: got %b want 0", obs_miss); else passed++;
    total++; if (obs_inst !== 32'h44) $display("FAIL hit_inst: got %h want 44", obs_inst); else passed++;
    total++; if (obs_lat !== 1) $display("FAIL hit_latency: got %0d want 1", obs_lat); else passed++;
    total++; if (obs_nop_bad !== 1'b0) $display("FAIL hit_nop_idle: got %b want 0", obs_nop_bad); else passed++;
  endtask

  task automatic test_conflict();
    bit h; logic [31:0] e;
    transact(32'h0000_0100, 1, 1, -1, -1, h, e);
    total++; if (obs_miss !== 1'b1) $display("FAIL conflict_miss: got %b want 1", obs_miss); else passed++;
    total++; if (obs_mem_addr !== 32'h100) $display("FAIL conflict_mem_addr: got %h want 100", obs_mem_addr); else passed++;
    total++; if (obs_inst !== e) $display("FAIL conflict_inst: got %h want %h", obs_inst, e); else passed++;
    transact(32'h0000_0000, 0, 0, -1, -1, h, e);
    total++; if (obs_miss !== 1'b1) $display("FAIL conflict_remiss: got %b want 1", obs_miss); else passed++;
    total++; if (obs_inst !== 32'h11) $display("FAIL conflict_remiss_inst: got %h want 11", obs_inst); else passed++;
  endtask

  task automatic test_flush();
    bit h; logic [31:0] e;
    flush_pulse();
    transact(32'h0000_0008, 0, 0, -1, -1, h, e);
    total++; if (obs_miss !== 1'b1) $display("FAIL flush_idle_miss: got %b want 1", obs_miss); else passed++;
    total++; if (obs_inst !== 32'h33) $display("FAIL flush_idle_inst: got %h want 33", obs_inst); else passed++;
    transact(32'h0000_0008, 0, 0, 1, -1, h, e);
    total++; if (obs_miss !== 1'b0) $display("FAIL flush_tag_hit: got %b want 0", obs_miss); else passed++;
    total++; if (obs_inst !== 32'h33) $display("FAIL flush_tag_inst: got %h want 33", obs_inst); else passed++;
    transact(32'h0000_0008, 0, 0, -1, -1, h, e);
    total++; if (obs_miss !== 1'b1) $display("FAIL flush_tag_after: got %b want 1", obs_miss); else passed++;
    transact(32'h0000_0004, 0, 0, 0, -1, h, e);
    total++; if (obs_miss !== 1'b1) $display("FAIL flush_with_req_miss: got %b want 1", obs_miss); else passed++;
    total++; if (obs_inst !== 32'h22) $display("FAIL flush_with_req_inst: got %h want 22", obs_inst); else passed++;
    transact(32'h0000_0020, 1, 0, 5, -1, h, e);
    total++; if (obs_inst !== e) $display("FAIL flush_fill_inst: got %h want %h", obs_inst, e); else passed++;
    total++; if (obs_acks !== 1) $display("FAIL flush_fill_acks: got %0d want 1", obs_acks); else passed++;
    transact(32'h0000_0020, 0, 0, -1, -1, h, e);
    total++; if (obs_miss !== 1'b1) $display("FAIL flush_fill_after: got %b want 1", obs_miss); else passed++;
  endtask

  task automatic test_reset_mid_fill();
    bit h; logic [31:0] e;
    flush_pulse();
    run_req(32'h0000_0000, 0, 0, -1, -1, 2);
    rst = 1'b0;
    step();
    total++; if (bus.cache_ack !== 1'b0) $display("FAIL midrst_ack: got %b want 0", bus.cache_ack); else passed++;
    total++; if (bus.inst !== NOP) $display("FAIL midrst_inst: got %h want %h", bus.inst, NOP); else passed++;
    total++; if (bus.mem_req !== 1'b0) $display("FAIL midrst_mem_req: got %b want 0", bus.mem_req); else passed++;
    total++; if (bus.mem_addr !== 32'h0) $display("FAIL midrst_mem_addr: got %h want 0", bus.mem_addr); else passed++;
    rst = 1'b1;
    model_invalidate();
    for (int b = 0; b < 2; b++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = $urandom;
      step();
      total++; if (bus.cache_ack !== 1'b0) $display("FAIL stray_beat_ack: got %b want 0", bus.cache_ack); else passed++;
      total++; if (bus.mem_req !== 1'b0) $display("FAIL stray_beat_req: got %b want 0", bus.mem_req); else passed++;
    end
    idle_inputs();
    step();
    transact(32'h0000_0000, 1, 0, -1, -1, h, e);
    total++; if (obs_miss !== 1'b1) $display("FAIL midrst_remiss: got %b want 1", obs_miss); else passed++;
    total++; if (obs_inst !== 32'h11) $display("FAIL midrst_inst_after: got %h want 11", obs_inst); else passed++;
  endtask

  task automatic test_ignored_req();
    bit h; logic [31:0] e;
    flush_pulse();
    transact(32'h0000_01C0, 3, 0, -1, 2, h, e);
    total++; if (obs_acks !== 1) $display("FAIL ignored_req_acks: got %0d want 1", obs_acks); else passed++;
    total++; if (obs_mem_addr !== 32'h1C0) $display("FAIL ignored_req_mem_addr: got %h want 1c0", obs_mem_addr); else passed++;
    total++; if (obs_inst !== e) $display("FAIL ignored_req_inst: got %h want %h", obs_inst, e); else passed++;
    transact(32'h0000_01C4, 0, 0, -1, 1, h, e);
    total++; if (obs_acks !== 1) $display("FAIL ack_cycle_req_acks: got %0d want 1", obs_acks); else passed++;
    total++; if (obs_inst !== e) $display("FAIL ack_cycle_req_inst: got %h want %h", obs_inst, e); else passed++;
    transact(32'h0000_0040, 0, 0, -1, -1, h, e);
    total++; if (obs_miss !== 1'b1) $display("FAIL ignored_addr_not_filled: got %b want 1", obs_miss); else passed++;
  endtask

  task automatic test_random();
    bit h; logic [31:0] e; logic [31:0] a;
    int g, gap, fl, st, exp_lat;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) memimg[$urandom_range(0, 767)] = $urandom;
      a   = $urandom_range(0, 2) * 1024 + $urandom_range(0, LINES * WORDS - 1) * 4 + $urandom_range(0, 3);
      g   = $urandom_range(0, 3);
      gap = $urandom_range(0, 2);
      fl  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
      st  = ($urandom_range(0, 5) == 0) ? 1 : -1;
      transact(a, g, gap, fl, st, h, e);
      exp_lat = h ? 1 : 3 + g + WORDS + obs_gaps;
      total++; if (obs_inst !== e) $display("FAIL rnd_inst a=%h: got %h want %h", a, obs_inst, e); else passed++;
      total++; if (obs_lat !== exp_lat) $display("FAIL rnd_latency a=%h: got %0d want %0d", a, obs_lat, exp_lat); else passed++;
      total++; if (obs_acks !== 1) $display("FAIL rnd_acks a=%h: got %0d want 1", a, obs_acks); else passed++;
      total++; if (obs_miss !== !h) $display("FAIL rnd_miss a=%h: got %b want %b", a, obs_miss, !h); else passed++;
      total++; if (obs_addr_bad !== 1'b0) $display("FAIL rnd_mem_addr_rule a=%h: got %b want 0", a, obs_addr_bad); else passed++;
      total++; if (obs_nop_bad !== 1'b0) $display("FAIL rnd_nop a=%h: got %b want 0", a, obs_nop_bad); else passed++;
      if (!h) begin
        total++;
        if (obs_mem_addr !== line_base(a)) $display("FAIL rnd_mem_addr a=%h: got %h want %h", a, obs_mem_addr, line_base(a));
        else passed++;
      end
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush();
    test_reset_mid_fill();
    test_ignored_req();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
